// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared flag bit positions and condition encodings
// Imported by the status register unit and the ID-stage condition checker.
package arm_pkg;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Single decode point so the hazard check and the condition checker cannot drift apart.
  function automatic logic cond_uses_flags(input logic [3:0] cond);
    return !((cond == COND_AL) || (cond == COND_NV));
  endfunction

endpackage

// File: rtl/sr_unit.sv
// rtl/sr_unit.sv - status flag register with EX bypass and flag-writer hazard tracking
// Counts in-flight flag setters so the ID stage stalls until their flags are visible.
module sr_unit
  import arm_pkg::*;
#(
  parameter bit BYPASS = 1'b1,
  parameter int PEND_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       freeze,
  input  logic       flush,
  input  logic       id_issue,
  input  logic       id_s,
  input  logic [3:0] id_cond,
  input  logic       ex_valid,
  input  logic       ex_s,
  input  logic [3:0] ex_flags,
  input  logic       ex_busy,
  input  logic       msr_we,
  input  logic [3:0] msr_data,
  output logic [3:0] sr,
  output logic       flag_hazard
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [3:0]        sr_q;
  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic              ex_live;
  logic              commit;
  logic              inc;
  logic              flag_use;
  logic              fwd_ok;

  assign ex_live  = ex_valid & ex_s & ~ex_busy;
  assign commit   = ex_live & ~freeze;
  assign inc      = id_issue & id_s & ~freeze & ~flush;
  assign flag_use = cond_uses_flags(id_cond);
  assign fwd_ok   = BYPASS & (pend_q == PEND_W'(1)) & ex_live;

  // Forwarding is masked during reset so sr reads the cleared register.
  assign sr          = (BYPASS && rst_n && ex_live) ? ex_flags : sr_q;
  assign flag_hazard = flag_use & (pend_q != '0) & ~fwd_ok;

  // The EX result is younger than the WB status write, so it wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= 4'b0000;
    end else if (commit) begin
      sr_q <= ex_flags;
    end else if (msr_we) begin
      sr_q <= msr_data;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (!freeze && flush) begin
      pend_d = '0;
    end else if (inc && !commit) begin
      pend_d = (pend_q == PEND_MAX) ? pend_q : pend_q + PEND_W'(1);
    end else if (commit && !inc) begin
      pend_d = (pend_q == '0) ? pend_q : pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  a_pend_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc && !commit && (pend_q == PEND_MAX)));

  a_pend_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(commit && !inc && !flush && (pend_q == '0)));

endmodule

// File: doc/sr_unit.md
SR_UNIT -- requirements
Module: sr_unit

Interface
REQ-001 SHALL have parameter BYPASS, default 1, meaning EX-stage flags are forwarded combinationally to the ID-stage sr output.
REQ-002 SHALL have parameter PEND_W, default 2, giving the width of the in-flight flag-writer counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port freeze, input, 1, pipeline stall: holds all state.
REQ-006 SHALL have port flush, input, 1, branch-taken squash of ID/EX contents.
REQ-007 SHALL have port id_issue, input, 1, ID-stage instruction advances to EX this cycle.
REQ-008 SHALL have port id_s, input, 1, the issuing instruction sets flags (S bit).
REQ-009 SHALL have port id_cond, input, 4, condition field of the ID-stage instruction.
REQ-010 SHALL have port ex_valid, input, 1, EX stage holds a live instruction.
REQ-011 SHALL have port ex_s, input, 1, EX instruction sets flags.
REQ-012 SHALL have port ex_flags, input, 4, ALU result flags {N,Z,C,V}.
REQ-013 SHALL have port ex_busy, input, 1, EX result not yet final (multi-cycle op).
REQ-014 SHALL have port msr_we, input, 1, explicit status write from WB.
REQ-015 SHALL have port msr_data, input, 4, explicit status value {N,Z,C,V}.
REQ-016 SHALL have port sr, output, 4, flags {N,Z,C,V} presented to the ID-stage condition checker.
REQ-017 SHALL have port flag_hazard, output, 1, the ID instruction must stall because its flags are not yet available.

Function
REQ-018 SHALL hold a 4-bit register sr_q; the bit order is N=3, Z=2, C=1, V=0.
REQ-019 SHALL commit ex_flags into sr_q at the clock edge when ex_valid & ex_s & !ex_busy & !freeze.
REQ-020 SHALL, when msr_we is asserted in the same cycle as an EX commit, take the EX commit; the WB write is older and loses.
REQ-021 SHALL, when msr_we is asserted with no EX commit, load msr_data at the clock edge regardless of freeze.
REQ-022 SHALL drive sr = ex_flags when BYPASS=1 & ex_valid & ex_s & !ex_busy, else sr = sr_q.
REQ-023 SHALL keep a pending counter: +1 on id_issue & id_s & !freeze & !flush; -1 on an EX commit.
REQ-024 SHALL leave the pending counter unchanged when the increment and decrement occur in the same cycle.
REQ-025 SHALL saturate the pending counter at 2^PEND_W-1 and raise a simulation assertion on overflow or underflow.
REQ-026 SHALL clear the pending counter on flush, except for a commit occurring in that same cycle, which still updates sr_q.
REQ-027 SHALL compute a combinational flag_use, true for id_cond in 0000..1101, false for 1110 (AL) and 1111.
REQ-028 SHALL assert flag_hazard = flag_use & (pending != 0) & !fwd_ok.
REQ-029 SHALL define fwd_ok = BYPASS & (pending == 1) & ex_valid & ex_s & !ex_busy.
REQ-030 SHALL not gate flag_hazard with freeze; the hazard is a pure function of the current state.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear sr_q to 4'b0000 and the pending counter to 0.
REQ-032 SHALL therefore present sr = 0 and flag_hazard = 0 while reset is held, with BYPASS forwarding masked.
REQ-033 SHALL discard an in-flight commit or MSR write when reset is asserted mid-operation.
REQ-034 SHALL produce the first update on the first rising edge after rst_n deasserts.

Structure
REQ-035 SHALL place the flag bit indices (N_BIT..V_BIT) and the AL and NV condition encodings in the shared arm_pkg package.
REQ-036 SHALL use no sub-module; the counter, register and hazard logic are flat.
REQ-037 SHALL keep its condition decode consistent with the ID-stage condition checker it feeds.

Verification
REQ-038 SHALL cover: reset with ex_flags=4'hF and ex_valid=ex_s=1 -> sr=0, flag_hazard=0 until the edge after release.
REQ-039 SHALL cover: a commit of ex_flags=4'b0100 -> sr=4'b0100 in the same cycle (bypass) and sr_q=4'b0100 after the edge.
REQ-040 SHALL cover: a flag-setting issue, then id_cond=0000 with ex_busy=1 for 3 cycles -> flag_hazard=1 for 3 cycles, cleared in the cycle ex_busy drops.
REQ-041 SHALL cover: msr_we with msr_data=4'b1001 colliding with an EX commit of 4'b0010 -> sr_q=4'b0010.
REQ-042 SHALL cover: two back-to-back S issues, then a flush -> pending=0 and flag_hazard=0 next cycle.
REQ-043 SHALL cover: id_cond=1110 with pending=2 -> flag_hazard=0; with BYPASS=0 and pending=1 plus a live EX commit -> flag_hazard=1.
